// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for a multicycle RV32I core (lw, sw, R-type, I-type ALU,
//   beq, jal). It steps one shared datapath through fetch, decode, execute,
//   memory and writeback, and stalls on the memory-ready handshake.
//
// Ports
//   clk        core clock
//   reset      synchronous, active-high reset
//   op         opcode, IR[6:0]
//   funct3     IR[14:12], used here only to check lw/sw legality
//   zero       ALU zero flag (beq outcome)
//   mem_ready  memory completed the current access this cycle
//   mem_req    memory access request
//   MemWrite   store strobe
//   IRWrite    load IR and OldPC
//   PCWrite    PC write enable = PCUpdate | (Branch & zero)
//   RegWrite   register-file write enable
//   AdrSrc     memory address: 0 = PC, 1 = ALUOut
//   ALUSrcA    00 = PC, 01 = OldPC, 10 = rd1
//   ALUSrcB    00 = rd2, 01 = imm, 10 = constant 4
//   ResultSrc  00 = ALUOut, 01 = Data, 10 = ALUResult
//   ImmSrc     00 = I, 01 = S, 10 = B, 11 = J (decoded from op)
//   ALUOp      00 = add, 01 = sub, 10 = funct-decoded
//   illegal    sticky illegal-instruction flag, cleared only by reset
//
// Parameter
//   RESET_PC_HOLD  extra FETCH cycles after reset before the first request
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned RESET_PC_HOLD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] ALUOp,
  output logic       illegal
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [2:0] F3_WORD = 3'b010;

  localparam int unsigned HW = (RESET_PC_HOLD > 0) ? $clog2(RESET_PC_HOLD + 1) : 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_PC_HOLD);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ILLEGAL
  } state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          illegal_q;
  logic          holding;
  logic          pc_update;
  logic          branch;

  assign holding = (hold_cnt != '0);

  // Decode-step dispatch; lw/sw are only legal with a word-sized funct3.
  function automatic state_t decode_next(input logic [6:0] o, input logic [2:0] f3);
    case (o)
      OP_LW, OP_SW: decode_next = (f3 == F3_WORD) ? S_MEMADR : S_ILLEGAL;
      OP_R:         decode_next = S_EXECR;
      OP_I:         decode_next = S_EXECI;
      OP_BEQ:       decode_next = S_BEQ;
      OP_JAL:       decode_next = S_JAL;
      default:      decode_next = S_ILLEGAL;
    endcase
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
      hold_cnt  <= HOLD_INIT;
    end else begin
      case (state)
        S_FETCH: begin
          if (holding)        hold_cnt <= hold_cnt - HW'(1);
          else if (mem_ready) state    <= S_DECODE;
        end
        S_DECODE: begin
          state <= decode_next(op, funct3);
          if (decode_next(op, funct3) == S_ILLEGAL) illegal_q <= 1'b1;
        end
        S_MEMADR:   state <= (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BEQ:      state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_ILLEGAL:  state <= S_ILLEGAL;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Output decode. Reset forces every output low in the same cycle so an
  // in-flight store or writeback is dropped immediately.
  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    mem_req   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    ALUOp     = 2'b00;
    pc_update = 1'b0;
    branch    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          // During the post-reset hold the request is withheld, so neither
          // IR nor PC may be written.
          mem_req   = !holding;
          IRWrite   = mem_ready && !holding;
          pc_update = mem_ready && !holding;
          ALUSrcB   = 2'b10;
          ResultSrc = 2'b10;
        end
        S_DECODE: begin
          ALUSrcA = 2'b01;
          ALUSrcB = 2'b01;
        end
        S_MEMADR: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
        end
        S_MEMREAD: begin
          mem_req = 1'b1;
          AdrSrc  = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req  = 1'b1;
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECR: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b10;
        end
        S_EXECI: begin
          ALUSrcA = 2'b10;
          ALUSrcB = 2'b01;
          ALUOp   = 2'b10;
        end
        S_ALUWB: RegWrite = 1'b1;
        S_BEQ: begin
          ALUSrcA = 2'b10;
          ALUOp   = 2'b01;
          branch  = 1'b1;
        end
        S_JAL: begin
          ALUSrcA   = 2'b01;
          ALUSrcB   = 2'b10;
          pc_update = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign PCWrite = pc_update | (branch & zero);
  assign illegal = !reset && illegal_q;

  always_comb begin
    ImmSrc = 2'b00;
    if (!reset) begin
      case (op)
        OP_SW:   ImmSrc = 2'b01;
        OP_BEQ:  ImmSrc = 2'b10;
        OP_JAL:  ImmSrc = 2'b11;
        default: ImmSrc = 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Each stimulus cycle pushes the
//   expected output vector into a queue; a monitor on the falling edge pops
//   and compares against the DUT. A second instance with RESET_PC_HOLD=2
//   exercises the post-reset fetch hold.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] ADD  = 7'b0110011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b1111111;

  typedef enum {
    T_RST, T_F, T_D, T_MA, T_MR, T_MWB, T_MW, T_ER, T_EI, T_AWB, T_BEQ, T_JAL, T_ILL
  } tst_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       adr_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] alu_op;
    logic       illegal;
    logic       h_req;
    logic       h_ir;
  } obs_t;

  typedef struct {
    obs_t  v;
    string tag;
  } item_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reset2 = 1'b1;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUOp;

  logic       h_mem_req, h_MemWrite, h_IRWrite, h_PCWrite, h_RegWrite, h_AdrSrc, h_illegal;
  logic [1:0] h_ALUSrcA, h_ALUSrcB, h_ResultSrc, h_ImmSrc, h_ALUOp;

  item_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUOp(ALUOp), .illegal(illegal)
  );

  multicycle_ctrl #(.RESET_PC_HOLD(2)) dut_hold (
    .clk(clk), .reset(reset2), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .mem_req(h_mem_req), .MemWrite(h_MemWrite),
    .IRWrite(h_IRWrite), .PCWrite(h_PCWrite), .RegWrite(h_RegWrite),
    .AdrSrc(h_AdrSrc), .ALUSrcA(h_ALUSrcA), .ALUSrcB(h_ALUSrcB),
    .ResultSrc(h_ResultSrc), .ImmSrc(h_ImmSrc), .ALUOp(h_ALUOp), .illegal(h_illegal)
  );

  // Expected outputs of each controller state, taken from the state table.
  function automatic obs_t expect_of(input tst_t s, input logic rdy, input logic z,
                                     input logic [1:0] imm, input logic hr, input logic hi);
    obs_t o;
    o = '0;
    o.h_req = hr;
    o.h_ir  = hi;
    if (s != T_RST) o.imm_src = imm;
    case (s)
      T_F:   begin o.mem_req = 1'b1; o.src_b = 2'b10; o.result_src = 2'b10;
                   o.ir_write = rdy; o.pc_write = rdy; end
      T_D:   begin o.src_a = 2'b01; o.src_b = 2'b01; end
      T_MA:  begin o.src_a = 2'b10; o.src_b = 2'b01; end
      T_MR:  begin o.mem_req = 1'b1; o.adr_src = 1'b1; end
      T_MWB: begin o.result_src = 2'b01; o.reg_write = 1'b1; end
      T_MW:  begin o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_write = 1'b1; end
      T_ER:  begin o.src_a = 2'b10; o.alu_op = 2'b10; end
      T_EI:  begin o.src_a = 2'b10; o.src_b = 2'b01; o.alu_op = 2'b10; end
      T_AWB: o.reg_write = 1'b1;
      T_BEQ: begin o.src_a = 2'b10; o.alu_op = 2'b01; o.pc_write = z; end
      T_JAL: begin o.src_a = 2'b01; o.src_b = 2'b10; o.pc_write = 1'b1; end
      T_ILL: o.illegal = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  // One clock cycle of stimulus plus its expected response.
  task automatic cyc(input tst_t s, input logic rst, input logic [6:0] o,
                     input logic [2:0] f, input logic rdy, input logic z,
                     input logic [1:0] imm, input string tag,
                     input logic rst2 = 1'b1, input logic hr = 1'b0, input logic hi = 1'b0);
    item_t it;
    @(posedge clk);
    #1;
    reset     = rst;
    reset2    = rst2;
    op        = o;
    funct3    = f;
    mem_ready = rdy;
    zero      = z;
    it.v   = expect_of(s, rdy, z, imm, hr, hi);
    it.tag = tag;
    exp_q.push_back(it);
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      item_t it;
      obs_t  act;
      it  = exp_q.pop_front();
      act = {mem_req, MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, ALUSrcA, ALUSrcB,
             ResultSrc, ImmSrc, ALUOp, illegal, h_mem_req, h_IRWrite};
      n_tests++;
      if (act !== it.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", it.tag, act, it.v);
      end
    end
  end

  initial begin
    // Reset
    cyc(T_RST, 1, ADD, 3'b000, 1, 1, 2'b00, "reset_0");
    cyc(T_RST, 1, ADD, 3'b000, 1, 1, 2'b00, "reset_1");

    // add x3,x1,x2
    cyc(T_F,   0, ADD, 3'b000, 1, 0, 2'b00, "add_fetch");
    cyc(T_D,   0, ADD, 3'b000, 1, 0, 2'b00, "add_decode");
    cyc(T_ER,  0, ADD, 3'b000, 1, 0, 2'b00, "add_execr");
    cyc(T_AWB, 0, ADD, 3'b000, 1, 0, 2'b00, "add_aluwb");

    // lw with two stall cycles in MEMREAD; mem_ready high in DECODE/MEMADR is ignored
    cyc(T_F,   0, LW, 3'b010, 1, 0, 2'b00, "lw_fetch");
    cyc(T_D,   0, LW, 3'b010, 1, 0, 2'b00, "lw_decode");
    cyc(T_MA,  0, LW, 3'b010, 1, 0, 2'b00, "lw_memadr");
    cyc(T_MR,  0, LW, 3'b010, 0, 0, 2'b00, "lw_memread_stall0");
    cyc(T_MR,  0, LW, 3'b010, 0, 0, 2'b00, "lw_memread_stall1");
    cyc(T_MR,  0, LW, 3'b010, 1, 0, 2'b00, "lw_memread_done");
    cyc(T_MWB, 0, LW, 3'b010, 0, 0, 2'b00, "lw_memwb");

    // beq taken
    cyc(T_F,   0, BEQ, 3'b000, 1, 1, 2'b10, "beq_t_fetch");
    cyc(T_D,   0, BEQ, 3'b000, 0, 1, 2'b10, "beq_t_decode");
    cyc(T_BEQ, 0, BEQ, 3'b000, 0, 1, 2'b10, "beq_t_exec");

    // beq not taken, with one fetch stall cycle first
    cyc(T_F,   0, BEQ, 3'b000, 0, 0, 2'b10, "beq_n_fetch_stall");
    cyc(T_F,   0, BEQ, 3'b000, 1, 0, 2'b10, "beq_n_fetch");
    cyc(T_D,   0, BEQ, 3'b000, 0, 0, 2'b10, "beq_n_decode");
    cyc(T_BEQ, 0, BEQ, 3'b000, 0, 0, 2'b10, "beq_n_exec");

    // jal
    cyc(T_F,   0, JAL, 3'b000, 1, 0, 2'b11, "jal_fetch");
    cyc(T_D,   0, JAL, 3'b000, 1, 0, 2'b11, "jal_decode");
    cyc(T_JAL, 0, JAL, 3'b000, 1, 0, 2'b11, "jal_exec");
    cyc(T_AWB, 0, JAL, 3'b000, 1, 0, 2'b11, "jal_aluwb");

    // addi
    cyc(T_F,   0, ADDI, 3'b000, 1, 0, 2'b00, "addi_fetch");
    cyc(T_D,   0, ADDI, 3'b000, 0, 0, 2'b00, "addi_decode");
    cyc(T_EI,  0, ADDI, 3'b000, 0, 0, 2'b00, "addi_execi");
    cyc(T_AWB, 0, ADDI, 3'b000, 0, 0, 2'b00, "addi_aluwb");

    // sw, no stall
    cyc(T_F,   0, SW, 3'b010, 1, 0, 2'b01, "sw_fetch");
    cyc(T_D,   0, SW, 3'b010, 0, 0, 2'b01, "sw_decode");
    cyc(T_MA,  0, SW, 3'b010, 0, 0, 2'b01, "sw_memadr");
    cyc(T_MW,  0, SW, 3'b010, 1, 0, 2'b01, "sw_memwrite");

    // Illegal opcode, sticky for 20 cycles, then reset clears it
    cyc(T_F,   0, BAD, 3'b000, 1, 0, 2'b00, "bad_fetch");
    cyc(T_D,   0, BAD, 3'b000, 1, 0, 2'b00, "bad_decode");
    for (int i = 0; i < 20; i++)
      cyc(T_ILL, 0, BAD, 3'b000, logic'(i[0]), 1, 2'b00, "bad_sticky");
    cyc(T_RST, 1, BAD, 3'b000, 1, 0, 2'b00, "bad_reset");
    cyc(T_F,   0, ADD, 3'b000, 0, 0, 2'b00, "bad_after_reset");

    // lw with an illegal funct3
    cyc(T_F,   0, LW, 3'b011, 1, 0, 2'b00, "lwf3_fetch");
    cyc(T_D,   0, LW, 3'b011, 0, 0, 2'b00, "lwf3_decode");
    cyc(T_ILL, 0, LW, 3'b011, 0, 0, 2'b00, "lwf3_illegal0");
    cyc(T_ILL, 0, LW, 3'b011, 1, 0, 2'b00, "lwf3_illegal1");
    cyc(T_RST, 1, LW, 3'b011, 0, 0, 2'b00, "lwf3_reset");

    // sw stalled in MEMWRITE, aborted by a one-cycle reset
    cyc(T_F,   0, SW, 3'b010, 1, 0, 2'b01, "swab_fetch");
    cyc(T_D,   0, SW, 3'b010, 0, 0, 2'b01, "swab_decode");
    cyc(T_MA,  0, SW, 3'b010, 0, 0, 2'b01, "swab_memadr");
    cyc(T_MW,  0, SW, 3'b010, 0, 0, 2'b01, "swab_stall0");
    cyc(T_MW,  0, SW, 3'b010, 0, 0, 2'b01, "swab_stall1");
    cyc(T_RST, 1, SW, 3'b010, 0, 0, 2'b01, "swab_reset");
    cyc(T_F,   0, ADD, 3'b000, 0, 0, 2'b00, "swab_refetch_wait");
    cyc(T_F,   0, ADD, 3'b000, 1, 0, 2'b00, "swab_refetch");
    cyc(T_D,   0, ADD, 3'b000, 0, 0, 2'b00, "swab_add_decode");
    cyc(T_ER,  0, ADD, 3'b000, 0, 0, 2'b00, "swab_add_execr");
    cyc(T_AWB, 0, ADD, 3'b000, 0, 0, 2'b00, "swab_add_aluwb");

    // Post-reset fetch hold on the RESET_PC_HOLD=2 instance (main DUT held in reset)
    cyc(T_RST, 1, ADD, 3'b000, 1, 0, 2'b00, "hold_reset", 1, 0, 0);
    cyc(T_RST, 1, ADD, 3'b000, 1, 0, 2'b00, "hold_cycle1", 0, 0, 0);
    cyc(T_RST, 1, ADD, 3'b000, 1, 0, 2'b00, "hold_cycle2", 0, 0, 0);
    cyc(T_RST, 1, ADD, 3'b000, 1, 0, 2'b00, "hold_fetch", 0, 1, 1);
    cyc(T_RST, 1, ADD, 3'b000, 1, 0, 2'b00, "hold_decode", 0, 0, 0);

    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
